// File: rtl/mp_adder_ctrl.sv
// Multi-precision add sequencer: one shared BIT_WIDTH adder walks the operands
// word by word, least-significant first, with the carry registered between words.

module adder_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] i_a,
  input  logic [BIT_WIDTH-1:0] i_b,
  input  logic                 i_carry_in,
  output logic [BIT_WIDTH-1:0] o_sum,
  output logic                 o_carry_out
);
  logic [BIT_WIDTH:0] w_carry;

  assign w_carry[0] = i_carry_in;

  genvar gi;
  generate
    for (gi = 0; gi < BIT_WIDTH; gi++) begin : g_fa
      assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
      assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_carry_out = w_carry[BIT_WIDTH];
endmodule

module mp_adder_ctrl #(
  parameter int BIT_WIDTH = 4,
  parameter int NUM_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           start,
  input  logic [BIT_WIDTH*NUM_WORDS-1:0] a,
  input  logic [BIT_WIDTH*NUM_WORDS-1:0] b,
  input  logic                           carry_in,
  output logic [BIT_WIDTH*NUM_WORDS-1:0] sum,
  output logic                           overflow,
  output logic                           busy,
  output logic                           done
);
  localparam int W     = BIT_WIDTH * NUM_WORDS;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_overflow;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_next;
  logic [IDX_W-1:0] w_idx_next;
  logic             w_carry_next;
  logic [W-1:0]     w_a_next;
  logic [W-1:0]     w_b_next;
  logic [W-1:0]     w_sum_next;
  logic             w_overflow_next;
  logic             w_busy_next;
  logic             w_done_next;

  logic [BIT_WIDTH-1:0] w_a_words [NUM_WORDS];
  logic [BIT_WIDTH-1:0] w_b_words [NUM_WORDS];
  logic [BIT_WIDTH-1:0] w_add_a;
  logic [BIT_WIDTH-1:0] w_add_b;
  logic [BIT_WIDTH-1:0] w_add_sum;
  logic                 w_add_cout;
  logic [W-1:0]         w_sum_upd;

  // Split the latched operands into words and merge the adder result back
  // into whichever sum word the index currently points at.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign w_a_words[gi] = r_a[gi*BIT_WIDTH +: BIT_WIDTH];
      assign w_b_words[gi] = r_b[gi*BIT_WIDTH +: BIT_WIDTH];
      assign w_sum_upd[gi*BIT_WIDTH +: BIT_WIDTH] =
        (r_idx == IDX_W'(gi)) ? w_add_sum : r_sum[gi*BIT_WIDTH +: BIT_WIDTH];
    end
  endgenerate

  assign w_add_a = w_a_words[r_idx];
  assign w_add_b = w_b_words[r_idx];

  adder_nbit #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_adder (
    .i_a         (w_add_a),
    .i_b         (w_add_b),
    .i_carry_in  (r_carry),
    .o_sum       (w_add_sum),
    .o_carry_out (w_add_cout)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_carry    <= w_carry_next;
      r_a        <= w_a_next;
      r_b        <= w_b_next;
      r_sum      <= w_sum_next;
      r_overflow <= w_overflow_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_carry_next    = r_carry;
    w_a_next        = r_a;
    w_b_next        = r_b;
    w_sum_next      = r_sum;
    w_overflow_next = r_overflow;
    w_done_next     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next    = S_ADD;
          w_a_next        = a;
          w_b_next        = b;
          w_carry_next    = carry_in;
          w_idx_next      = '0;
          w_sum_next      = '0;
          w_overflow_next = 1'b0;
        end
      end
      S_ADD: begin
        w_sum_next   = w_sum_upd;
        w_carry_next = w_add_cout;
        if (r_idx == LAST_IDX) begin
          w_overflow_next = w_add_cout;
          w_state_next    = S_DONE;
          w_done_next     = 1'b1;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Busy and done are registered from the next state so they never glitch.
  assign w_busy_next = (w_state_next != S_IDLE);

  assign sum      = r_sum;
  assign overflow = r_overflow;
  assign busy     = r_busy;
  assign done     = r_done;
endmodule

// File: tb/tb_mp_adder_ctrl.sv
// Directed and randomized checks of mp_adder_ctrl against a plain-arithmetic
// model: {overflow,sum} = a + b + carry_in, done five edges after acceptance.

module tb_mp_adder_ctrl;
  localparam int BW = 4;
  localparam int NW = 4;
  localparam int W  = BW * NW;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic [W-1:0] sum;
  logic         overflow;
  logic         busy;
  logic         done;

  int n_total;
  int n_pass;

  mp_adder_ctrl #(
    .BIT_WIDTH (BW),
    .NUM_WORDS (NW)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .sum      (sum),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One full operation observed over eight negedges after the accepting edge.
  // With poke set, start is pulsed during ADD and DONE with different operands.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input bit poke, input string tag);
    logic [W:0] exp;
    int done_cnt;
    int done_at;
    int busy_cnt;
    exp = {1'b0, ta} + {1'b0, tb_v} + (W+1)'(tcin);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; carry_in = tcin;
    @(posedge clk);
    done_cnt = 0; done_at = -1; busy_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) begin done_cnt++; done_at = k; end
      if (busy) busy_cnt++;
      if (k == 1) begin
        check({tag, " cleared_sum"}, 32'(sum), 32'(0));
        check({tag, " cleared_ovf"}, 32'(overflow), 32'(0));
      end
      if (k == 2) begin
        check({tag, " word0"}, 32'(sum), 32'(exp[BW-1:0]));
      end
      if (k == 6) begin
        check({tag, " sum"}, 32'(sum), 32'(exp[W-1:0]));
        check({tag, " ovf"}, 32'(overflow), 32'(exp[W]));
      end
      if (k == 1 || k == 3 || k == 6) begin
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
      end
      if (poke && (k == 2 || k == 5)) begin
        start = 1'b1;
        a = (k == 2) ? 16'hAAAA : W'($urandom);
        b = W'($urandom);
      end
    end
    check({tag, " done_count"}, 32'(done_cnt), 32'(1));
    check({tag, " done_edge"}, 32'(done_at), 32'(5));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(5));
    check({tag, " hold_sum"}, 32'(sum), 32'(exp[W-1:0]));
    check({tag, " hold_ovf"}, 32'(overflow), 32'(exp[W]));
    $display("op %s: a=0x%04h b=0x%04h cin=%0d -> sum=0x%04h ovf=%0d", tag, ta, tb_v, tcin, sum, overflow);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           dcnt;
    n_total = 0;
    n_pass  = 0;

    // Reset held with start high.
    n_rst = 1'b0; start = 1'b1; a = 16'h1234; b = 16'h4321; carry_in = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst sum", 32'(sum), 32'(0));
      check("rst ovf", 32'(overflow), 32'(0));
      check("rst busy", 32'(busy), 32'(0));
      check("rst done", 32'(done), 32'(0));
    end
    start = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    check("idle busy", 32'(busy), 32'(0));
    check("idle sum", 32'(sum), 32'(0));

    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "chain");
    run_op(16'h1234, 16'h1111, 1'b1, 1'b0, "cin1");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "cin2");
    run_op(16'h0001, 16'h0001, 1'b0, 1'b1, "busyprot");

    // Reset on the third ADD edge (edge 4 counting the accepting edge).
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'h0001; carry_in = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); n_rst = 1'b0;
    @(negedge clk);
    check("midrst sum", 32'(sum), 32'(0));
    check("midrst ovf", 32'(overflow), 32'(0));
    check("midrst busy", 32'(busy), 32'(0));
    check("midrst done", 32'(done), 32'(0));
    n_rst = 1'b1;
    dcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst no_done", 32'(dcnt), 32'(0));
    check("midrst idle", 32'(busy), 32'(0));
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, "after_rst");

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, (i % 4) == 0, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mp_adder_ctrl.md
Name: mp_adder_ctrl

Overview:
- Multi-precision add sequencer. Adds two NUM_WORDS*BIT_WIDTH-bit operands using one shared BIT_WIDTH-bit adder_nbit instance, one word per clock, least-significant word first.
- The carry is registered between words.
- Sits between a requesting controller (start/done handshake) and the adder datapath. Lets narrow adders service wide operands.

Parameters:
- BIT_WIDTH, 4: width of the adder_nbit instance and of one operand word.
- NUM_WORDS, 4: number of words per operand. Minimum 2. Total operand width W = BIT_WIDTH*NUM_WORDS.

Ports:
- clk  input  1  system clock, rising edge active.
- n_rst  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request pulse/level; accepted only in IDLE.
- a  input  W  operand A; sampled on the accepting edge only.
- b  input  W  operand B; sampled on the accepting edge only.
- carry_in  input  1  initial carry into word 0; sampled with a/b.
- sum  output  W  result register.
- overflow  output  1  carry out of the most-significant word.
- busy  output  1  high in ADD and DONE states.
- done  output  1  one-cycle pulse; sum/overflow valid.

Behaviour:
- Clock and reset: one clock (clk). Reset n_rst is synchronous and active-low.
- Reset (n_rst=0 at rising clk):
  - state=IDLE; word index=0; carry reg=0.
  - Operand regs=0; sum=0; overflow=0; busy=0; done=0.
  - Reset overrides every other input.
- Reset mid-operation: n_rst low during ADD or DONE aborts the add at that edge. No done pulse is issued. All outputs return to their reset values.
- States: IDLE, ADD, DONE. The state is registered.
- IDLE, start=1 at edge:
  - Latch a, b and carry_in into internal regs; idx=0.
  - Clear sum and overflow to 0.
  - Go to ADD.
- IDLE, start=0: hold; sum/overflow keep their last result.
- ADD, each edge:
  - The adder_nbit inputs are operand words [idx] and the carry reg.
  - sum word [idx] takes the adder sum; the carry reg takes the adder carry_out; idx increments.
  - At idx==NUM_WORDS-1: overflow takes the final carry_out and the FSM goes to DONE.
  - Exactly NUM_WORDS ADD cycles per operation.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: done is high during the cycle following the (NUM_WORDS+1)th rising edge, counting the accepting edge as edge 1. For the default parameters, done is high after 5 edges.
- start while busy=1, including in DONE: ignored, with no effect on operands or result. A new request must be presented while in IDLE. Minimum start-to-start spacing is NUM_WORDS+2 cycles.
- Output hold: sum and overflow hold from DONE until the next accepted start.
- Partial sum: upper sum words read 0 until written in ADD.
- Input stability: a, b and carry_in may change freely after the accepting edge without affecting the result.
- Arithmetic: unsigned modulo 2^W. The result is {overflow,sum} = a + b + carry_in.
- Glitch-free outputs: done, busy, sum and overflow are all registered outputs, never combinational from inputs.
- Index rules: idx never exceeds NUM_WORDS-1; idx resets to 0 on every accepted start.

Test Plan (BIT_WIDTH=4, NUM_WORDS=4):
- Reset: hold n_rst=0 for 2 clks with start=1 -> sum=0x0000, overflow=0, busy=0, done=0, no state change.
- Basic: a=0x00FF, b=0x0001, carry_in=0, start one cycle -> done pulses once, 5 edges after the start edge; sum=0x0100, overflow=0; busy high for exactly 5 cycles.
- Full carry chain: a=0xFFFF, b=0x0001 -> sum=0x0000, overflow=1.
- Carry in:
  - a=0x1234, b=0x1111, carry_in=1 -> sum=0x2346, overflow=0.
  - a=0xFFFF, b=0xFFFF, carry_in=1 -> sum=0xFFFF, overflow=1.
- Busy protection: start a=0x0001, b=0x0001; while busy, pulse start with a=0xAAAA and change a/b -> result is sum=0x0002, single done pulse, no second operation begins.
- Reset mid-op: start a=0xFFFF, b=0x0001; assert n_rst=0 on the 3rd ADD edge -> no done pulse, all outputs 0; a following start with a=0x0003, b=0x0004 gives sum=0x0007.
